// File: rtl/fsk_demod_pkg.sv
// Shared helpers for the M-ary FSK demodulator: tone count, widths and default thresholds.
package fsk_demod_pkg;

  function automatic int m_tones(input int bits);
    return 1 << bits;
  endfunction

  function automatic int samp_w(input int sps);
    return (sps > 1) ? $clog2(sps) : 1;
  endfunction

  // A symbol is exactly BITS_PER_SYM wide; the top builds its sym_t from this.
  function automatic int sym_w(input int bits);
    return bits;
  endfunction

  // Power-up table: 3/16, 3/32, 3/64 ... of the window length, highest tone first.
  function automatic int dflt_thresh(input int sps, input int i);
    return (3 * sps) >> (4 + i);
  endfunction

endpackage

// File: rtl/fsk_glitch_filter.sv
// Level filter: output follows the input only after GLITCH_LEN consecutive samples at the new level.
module fsk_glitch_filter #(
  parameter int GLITCH_LEN = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_in,
  output logic d_out
);
  localparam int RW = (GLITCH_LEN > 1) ? $clog2(GLITCH_LEN) : 1;

  logic [RW-1:0] run;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_out <= 1'b0;
      run   <= '0;
    end else if (d_in == d_out) begin
      run <= '0;
    end else if (run == RW'(GLITCH_LEN - 1)) begin
      d_out <= d_in;
      run   <= '0;
    end else begin
      run <= run + 1'b1;
    end
  end
endmodule

// File: rtl/fsk_demod_mary.sv
// M-ary FSK demodulator: counts filtered-level transitions per symbol window and
// maps the count onto a programmable threshold table.
module fsk_demod_mary
  import fsk_demod_pkg::*;
#(
  parameter int BITS_PER_SYM = 2,
  parameter int SPS          = 128,
  parameter int CNT_W        = 8,
  parameter int GLITCH_LEN   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    sym_sync,
  input  logic                    din,
  input  logic                    thresh_wr,
  input  logic [BITS_PER_SYM-1:0] thresh_idx,
  input  logic [CNT_W-1:0]        thresh_data,
  output logic [BITS_PER_SYM-1:0] dout,
  output logic                    dout_valid,
  output logic [CNT_W-1:0]        edge_cnt,
  output logic                    overflow
);
  localparam int M  = m_tones(BITS_PER_SYM);
  localparam int SW = samp_w(SPS);
  localparam logic [SW-1:0]    LAST = SW'(SPS - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef logic [sym_w(BITS_PER_SYM)-1:0] sym_t;

  logic sync1, sync2, filt_in, filt, filt_q, trans, sat, sat_nxt, last;
  logic [SW-1:0]               samp;
  logic [CNT_W-1:0]            cnt_nxt;
  logic [M-2:0][CNT_W-1:0]     thresh;
  sym_t                        decide;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) {sync2, sync1} <= 2'b00;
    else        {sync2, sync1} <= {sync1, din};
  end

  // Feeding the held level back in freezes the filter while the window is disabled.
  assign filt_in = en ? sync2 : filt;

  fsk_glitch_filter #(.GLITCH_LEN(GLITCH_LEN)) u_filt (
    .clk   (clk),
    .reset (reset),
    .d_in  (filt_in),
    .d_out (filt)
  );

  assign trans = filt ^ filt_q;
  assign last  = (samp == LAST);

  always_comb begin
    cnt_nxt = edge_cnt;
    sat_nxt = sat;
    if (trans) begin
      if (edge_cnt == CMAX) sat_nxt = 1'b1;
      else                  cnt_nxt = edge_cnt + 1'b1;
    end
    // Lowest index wins, so scan downwards and let each hit overwrite.
    decide = sym_t'(M - 1);
    for (int i = M - 2; i >= 0; i--)
      if (cnt_nxt > thresh[i]) decide = sym_t'(i);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_q     <= 1'b0;
      samp       <= '0;
      edge_cnt   <= '0;
      sat        <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      filt_q     <= filt;
      dout_valid <= 1'b0;
      if (sym_sync) begin
        samp     <= '0;
        edge_cnt <= '0;
        sat      <= 1'b0;
      end else if (en) begin
        if (last) begin
          samp       <= '0;
          edge_cnt   <= '0;
          sat        <= 1'b0;
          dout       <= decide;
          overflow   <= sat_nxt;
          dout_valid <= 1'b1;
        end else begin
          samp     <= samp + 1'b1;
          edge_cnt <= cnt_nxt;
          sat      <= sat_nxt;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < M - 1; i++) thresh[i] <= CNT_W'(dflt_thresh(SPS, i));
    end else if (thresh_wr && (int'(thresh_idx) <= M - 2)) begin
      thresh[thresh_idx] <= thresh_data;
    end
  end
endmodule
